// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
//   Shared definitions for the register-file write path: register/data widths,
//   the hard-wired zero register, the queued write request record and the
//   starvation FSM state type used by regfile_wr_arbiter.
//   No ports (package).
// -----------------------------------------------------------------------------
package mips_pkg;

  localparam int REG_AW = 5;
  localparam int DATA_W = 32;

  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

  // One pending register-file write
  typedef struct packed {
    logic [REG_AW-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_req_t;

  // Starvation FSM: NORMAL lets WB win; STALL forces a FIFO drain
  typedef enum logic [0:0] {
    ST_NORMAL = 1'b0,
    ST_STALL  = 1'b1
  } arb_state_t;

  // Writes to r0 are architecturally dropped, so every path qualifies on this
  function automatic logic addr_nz(input logic [REG_AW-1:0] a);
    return (a != REG_ZERO);
  endfunction

endpackage

// File: rtl/regwr_fifo.sv
// -----------------------------------------------------------------------------
// regwr_fifo
//   DEPTH-entry synchronous FIFO holding MDU results that lost arbitration for
//   the register-file write port. Also publishes which slots currently hold a
//   valid entry and the destination register of every slot, so the arbiter can
//   answer hazard-unit queries.
// Ports:
//   clk        clock
//   rst_n      synchronous active-low reset (empties the FIFO)
//   push       write din at the tail (ignored when full)
//   pop        drop the head entry (ignored when empty)
//   din        entry to push
//   dout       current head entry
//   empty      no valid entries
//   full       DEPTH valid entries
//   ent_valid  per-slot valid flags (slot index = storage index)
//   ent_addr   per-slot destination register
// -----------------------------------------------------------------------------
module regwr_fifo
  import mips_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              push,
  input  logic                              pop,
  input  wr_req_t                           din,
  output wr_req_t                           dout,
  output logic                              empty,
  output logic                              full,
  output logic [DEPTH-1:0]                  ent_valid,
  output logic [DEPTH-1:0][REG_AW-1:0]      ent_addr
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wr_req_t         mem_r [DEPTH];
  logic [PW-1:0]   rd_ptr_r;
  logic [PW-1:0]   wr_ptr_r;
  logic [CW-1:0]   count_r;
  logic            push_ok_s;
  logic            pop_ok_s;

  assign empty     = (count_r == {CW{1'b0}});
  assign full      = (count_r == CW'(DEPTH));
  assign push_ok_s = push & ~full;
  assign pop_ok_s  = pop & ~empty;
  assign dout      = mem_r[rd_ptr_r];

  // Pointer and occupancy update; pointers wrap naturally since DEPTH is 2^n
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_r <= {PW{1'b0}};
      wr_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; contents of empty slots are never observed, so no reset
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Slot i is valid when its distance from the read pointer is below the count
  always_comb begin
    logic [PW-1:0] off_v;
    off_v     = {PW{1'b0}};
    ent_valid = {DEPTH{1'b0}};
    ent_addr  = {(DEPTH*REG_AW){1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      off_v        = PW'(i) - rd_ptr_r;
      ent_valid[i] = ({1'b0, off_v} < count_r);
      ent_addr[i]  = mem_r[i].addr;
    end
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wr_arbiter
//   Shares the register file's single write port between the WB stage and the
//   multi-cycle MDU. WB has priority; MDU results that cannot be written at
//   once wait in regwr_fifo. A starvation counter raises stall_req so queued
//   results drain, and chk_hit1/2 tell the hazard unit whether a queued write
//   targets a register it is asking about.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   ce                    clock enable (low freezes state, blocks writes)
//   wb_we/addr/data       WB stage write request
//   mdu_valid/addr/data   MDU result; mdu_ready is the accept handshake
//   regwrite/writereg/writedata   register-file write port
//   stall_req             registered pipeline freeze request
//   chk_addr1/2, chk_hit1/2       hazard-unit queries against queued writes
// -----------------------------------------------------------------------------
module regfile_wr_arbiter
  import mips_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ce,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              mdu_valid,
  output logic              mdu_ready,
  input  logic [REG_AW-1:0] mdu_addr,
  input  logic [DATA_W-1:0] mdu_data,
  output logic              regwrite,
  output logic [REG_AW-1:0] writereg,
  output logic [DATA_W-1:0] writedata,
  output logic              stall_req,
  input  logic [REG_AW-1:0] chk_addr1,
  input  logic [REG_AW-1:0] chk_addr2,
  output logic              chk_hit1,
  output logic              chk_hit2
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  wr_req_t                        head_s;
  wr_req_t                        push_req_s;
  logic                           empty_s;
  logic                           full_s;
  logic [DEPTH-1:0]               ent_valid_s;
  logic [DEPTH-1:0][REG_AW-1:0]   ent_addr_s;
  logic                           hs_s;
  logic                           push_s;
  logic                           pop_s;
  logic                           bypass_s;
  logic                           wb_win_s;
  arb_state_t                     state_r;
  arb_state_t                     state_n_s;
  logic [CNT_W-1:0]               cnt_r;
  logic [CNT_W-1:0]               cnt_n_s;
  logic                           stall_req_r;

  // full is the pre-edge occupancy, so a same-cycle pop never frees a slot
  assign mdu_ready       = ce & rst_n & ~full_s;
  assign hs_s            = mdu_valid & mdu_ready;
  // r0 results are accepted but neither queued nor written
  assign push_s          = hs_s & addr_nz(mdu_addr) & ~bypass_s;
  assign push_req_s.addr = mdu_addr;
  assign push_req_s.data = mdu_data;
  assign stall_req       = stall_req_r;

  regwr_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_s),
    .pop       (pop_s),
    .din       (push_req_s),
    .dout      (head_s),
    .empty     (empty_s),
    .full      (full_s),
    .ent_valid (ent_valid_s),
    .ent_addr  (ent_addr_s)
  );

  // Write-port grant in priority order; the first matching source owns the port
  always_comb begin
    regwrite  = 1'b0;
    writereg  = REG_ZERO;
    writedata = {DATA_W{1'b0}};
    pop_s     = 1'b0;
    bypass_s  = 1'b0;
    wb_win_s  = 1'b0;
    if (!ce) begin
      regwrite = 1'b0;
    end else if ((state_r == ST_STALL) && !empty_s) begin
      // WB is frozen and will be re-presented, so only the FIFO drains
      regwrite  = 1'b1;
      writereg  = head_s.addr;
      writedata = head_s.data;
      pop_s     = 1'b1;
    end else if (wb_we && addr_nz(wb_addr)) begin
      regwrite  = 1'b1;
      writereg  = wb_addr;
      writedata = wb_data;
      wb_win_s  = 1'b1;
    end else if (!empty_s) begin
      regwrite  = 1'b1;
      writereg  = head_s.addr;
      writedata = head_s.data;
      pop_s     = 1'b1;
    end else if (hs_s && addr_nz(mdu_addr)) begin
      regwrite  = 1'b1;
      writereg  = mdu_addr;
      writedata = mdu_data;
      bypass_s  = 1'b1;
    end else begin
      regwrite = 1'b0;
    end
  end

  // Starvation FSM next state: count WB wins over a waiting head, then force a drain
  always_comb begin
    state_n_s = state_r;
    cnt_n_s   = cnt_r;
    if (!ce) begin
      state_n_s = state_r;
      cnt_n_s   = cnt_r;
    end else begin
      case (state_r)
        ST_NORMAL: begin
          if (!empty_s && wb_win_s) begin
            if (cnt_r == CNT_W'(STARVE_LIMIT - 1)) begin
              state_n_s = ST_STALL;
              cnt_n_s   = {CNT_W{1'b0}};
            end else begin
              cnt_n_s = cnt_r + CNT_W'(1);
            end
          end else begin
            cnt_n_s = {CNT_W{1'b0}};
          end
        end
        ST_STALL: begin
          cnt_n_s = {CNT_W{1'b0}};
          if (pop_s || empty_s) begin
            state_n_s = ST_NORMAL;
          end else begin
            state_n_s = ST_STALL;
          end
        end
        default: begin
          state_n_s = ST_NORMAL;
          cnt_n_s   = {CNT_W{1'b0}};
        end
      endcase
    end
  end

  // FSM state, starve count and the registered stall request
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_NORMAL;
      cnt_r       <= {CNT_W{1'b0}};
      stall_req_r <= 1'b0;
    end else begin
      state_r     <= state_n_s;
      cnt_r       <= cnt_n_s;
      stall_req_r <= (state_n_s == ST_STALL);
    end
  end

  // Hazard queries see only entries already stored, never this cycle's push
  always_comb begin
    chk_hit1 = 1'b0;
    chk_hit2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      chk_hit1 = chk_hit1 | (ent_valid_s[i] & (ent_addr_s[i] == chk_addr1));
      chk_hit2 = chk_hit2 | (ent_valid_s[i] & (ent_addr_s[i] == chk_addr2));
    end
    chk_hit1 = chk_hit1 & addr_nz(chk_addr1);
    chk_hit2 = chk_hit2 & addr_nz(chk_addr2);
  end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_wr_arbiter
//   Directed bench for regfile_wr_arbiter (DEPTH=2, STARVE_LIMIT=4). A
//   queue-based reference model is checked against the DUT on every falling
//   edge, and literal expectations are checked inside each directed scenario.
// -----------------------------------------------------------------------------
module tb_regfile_wr_arbiter;

  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic        clk;
  logic        rst_n;
  logic        ce;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        mdu_valid;
  logic        mdu_ready;
  logic [4:0]  mdu_addr;
  logic [31:0] mdu_data;
  logic        regwrite;
  logic [4:0]  writereg;
  logic [31:0] writedata;
  logic        stall_req;
  logic [4:0]  chk_addr1;
  logic [4:0]  chk_addr2;
  logic        chk_hit1;
  logic        chk_hit2;

  int tests_run;
  int tests_failed;

  regfile_wr_arbiter #(
    .DEPTH        (DEPTH),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ce        (ce),
    .wb_we     (wb_we),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .mdu_valid (mdu_valid),
    .mdu_ready (mdu_ready),
    .mdu_addr  (mdu_addr),
    .mdu_data  (mdu_data),
    .regwrite  (regwrite),
    .writereg  (writereg),
    .writedata (writedata),
    .stall_req (stall_req),
    .chk_addr1 (chk_addr1),
    .chk_addr2 (chk_addr2),
    .chk_hit1  (chk_hit1),
    .chk_hit2  (chk_hit2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [4:0]  mq_addr[$];
  logic [31:0] mq_data[$];
  int          m_starve;
  bit          m_stall;

  initial begin
    m_starve = 0;
    m_stall  = 1'b0;
  end

  always @(negedge clk) begin
    bit          e_ready, hs, e_we, e_pop, e_push, e_bypass, e_wbwin, e_hit1, e_hit2;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    if (!rst_n) begin
      chk("m_ready_rst", mdu_ready, 1'b0);
      mq_addr.delete();
      mq_data.delete();
      m_starve = 0;
      m_stall  = 1'b0;
    end else begin
      e_ready  = ce && (mq_addr.size() < DEPTH);
      hs       = mdu_valid && e_ready;
      e_we = 0; e_pop = 0; e_push = 0; e_bypass = 0; e_wbwin = 0;
      e_addr = 5'd0; e_data = 32'd0;
      if (ce) begin
        if (m_stall && mq_addr.size() > 0) begin
          e_we = 1; e_addr = mq_addr[0]; e_data = mq_data[0]; e_pop = 1;
        end else if (wb_we && wb_addr != 5'd0) begin
          e_we = 1; e_addr = wb_addr; e_data = wb_data; e_wbwin = 1;
        end else if (mq_addr.size() > 0) begin
          e_we = 1; e_addr = mq_addr[0]; e_data = mq_data[0]; e_pop = 1;
        end else if (hs && mdu_addr != 5'd0) begin
          e_we = 1; e_addr = mdu_addr; e_data = mdu_data; e_bypass = 1;
        end
        e_push = hs && (mdu_addr != 5'd0) && !e_bypass;
      end
      e_hit1 = 0; e_hit2 = 0;
      foreach (mq_addr[i]) begin
        if (chk_addr1 != 5'd0 && mq_addr[i] == chk_addr1) e_hit1 = 1;
        if (chk_addr2 != 5'd0 && mq_addr[i] == chk_addr2) e_hit2 = 1;
      end

      chk("m_regwrite", regwrite, e_we);
      if (e_we) begin
        chk("m_writereg", writereg, e_addr);
        chk("m_writedata", writedata, e_data);
      end
      chk("m_ready", mdu_ready, e_ready);
      chk("m_stall", stall_req, m_stall);
      chk("m_hit1", chk_hit1, e_hit1);
      chk("m_hit2", chk_hit2, e_hit2);

      if (ce) begin
        if (m_stall) begin
          if (e_pop || mq_addr.size() == 0) m_stall = 1'b0;
        end else if (mq_addr.size() > 0 && e_wbwin) begin
          m_starve++;
          if (m_starve == LIMIT) begin
            m_stall  = 1'b1;
            m_starve = 0;
          end
        end else begin
          m_starve = 0;
        end
        if (e_pop) begin
          void'(mq_addr.pop_front());
          void'(mq_data.pop_front());
        end
        if (e_push) begin
          mq_addr.push_back(mdu_addr);
          mq_data.push_back(mdu_data);
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic mv, input logic [4:0] ma, input logic [31:0] md);
    wb_we = we; wb_addr = wa; wb_data = wd;
    mdu_valid = mv; mdu_addr = ma; mdu_data = md;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    rst_n = 1'b0; ce = 1'b1;
    chk_addr1 = 5'd0; chk_addr2 = 5'd0;
    wb_we = 1'b0; wb_addr = 5'd0; wb_data = 32'd0;
    mdu_valid = 1'b0; mdu_addr = 5'd0; mdu_data = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Idle after reset
    chk_addr1 = 5'd7; chk_addr2 = 5'd3;
    idle();
    chk("idle_regwrite", regwrite, 1'b0);
    chk("idle_ready", mdu_ready, 1'b1);
    chk("idle_stall", stall_req, 1'b0);
    chk("idle_hit1", chk_hit1, 1'b0);
    chk("idle_hit2", chk_hit2, 1'b0);
    tick();

    // Bypass with empty FIFO
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h1234);
    chk("byp_regwrite", regwrite, 1'b1);
    chk("byp_writereg", writereg, 5'd5);
    chk("byp_writedata", writedata, 32'h1234);
    tick();
    chk_addr1 = 5'd5;
    idle();
    chk("byp_after_regwrite", regwrite, 1'b0);
    chk("byp_after_hit1", chk_hit1, 1'b0);
    tick();

    // WB vs MDU conflict
    chk_addr1 = 5'd7;
    drive(1'b1, 5'd3, 32'hAA, 1'b1, 5'd7, 32'hBB);
    chk("cf0_writereg", writereg, 5'd3);
    chk("cf0_writedata", writedata, 32'hAA);
    chk("cf0_hit1", chk_hit1, 1'b0);
    tick();
    idle();
    chk("cf1_writereg", writereg, 5'd7);
    chk("cf1_writedata", writedata, 32'hBB);
    chk("cf1_hit1", chk_hit1, 1'b1);
    tick();
    idle();
    chk("cf2_regwrite", regwrite, 1'b0);
    chk("cf2_hit1", chk_hit1, 1'b0);
    tick();

    // Starvation: one queued entry, WB busy every cycle
    drive(1'b1, 5'd3, 32'hAA, 1'b1, 5'd7, 32'hBB);
    chk("sv0_writereg", writereg, 5'd3);
    tick();
    for (int k = 1; k <= 4; k++) begin
      drive(1'b1, 5'd4, 32'hCC, 1'b0, 5'd0, 32'd0);
      chk("sv_wb_writereg", writereg, 5'd4);
      chk("sv_wb_stall", stall_req, 1'b0);
      tick();
    end
    chk("sv5_stall", stall_req, 1'b1);
    chk("sv5_writereg", writereg, 5'd7);
    chk("sv5_writedata", writedata, 32'hBB);
    tick();
    chk("sv6_stall", stall_req, 1'b0);
    chk("sv6_writereg", writereg, 5'd4);
    tick();

    // r0 from either source is never written
    drive(1'b1, 5'd0, 32'h11, 1'b0, 5'd0, 32'd0);
    chk("wb_r0_regwrite", regwrite, 1'b0);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hDEAD);
    chk("mdu_r0_ready", mdu_ready, 1'b1);
    chk("mdu_r0_regwrite", regwrite, 1'b0);
    tick();

    // Fill the FIFO while WB is busy, then r0 accepted but dropped
    drive(1'b1, 5'd4, 32'hCC, 1'b1, 5'd8, 32'h88);
    chk("fl0_ready", mdu_ready, 1'b1);
    tick();
    drive(1'b1, 5'd4, 32'hCC, 1'b1, 5'd9, 32'h99);
    chk("fl1_ready", mdu_ready, 1'b1);
    tick();
    drive(1'b1, 5'd4, 32'hCC, 1'b1, 5'd10, 32'h1010);
    chk("fl2_ready_full", mdu_ready, 1'b0);
    chk("fl2_writereg", writereg, 5'd4);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd10, 32'h1010);
    chk("fl3_ready_full", mdu_ready, 1'b0);
    chk("fl3_writereg", writereg, 5'd8);
    chk("fl3_writedata", writedata, 32'h88);
    tick();
    chk_addr2 = 5'd0;
    drive(1'b1, 5'd4, 32'hCC, 1'b1, 5'd0, 32'hDEAD);
    chk("fl4_ready", mdu_ready, 1'b1);
    chk("fl4_writereg", writereg, 5'd4);
    chk("fl4_hit2_r0", chk_hit2, 1'b0);
    tick();
    chk_addr1 = 5'd9;
    idle();
    chk("fl5_writereg", writereg, 5'd9);
    chk("fl5_writedata", writedata, 32'h99);
    chk("fl5_hit1", chk_hit1, 1'b1);
    tick();
    idle();
    chk("fl6_regwrite", regwrite, 1'b0);
    chk("fl6_hit1", chk_hit1, 1'b0);
    tick();

    // ce=0 freezes the starve count; stall arrives after 4 counted WB wins
    chk_addr1 = 5'd11;
    drive(1'b1, 5'd3, 32'hAA, 1'b1, 5'd11, 32'h55);
    chk("ce0_writereg", writereg, 5'd3);
    tick();
    repeat (2) begin
      drive(1'b1, 5'd3, 32'hAA, 1'b0, 5'd0, 32'd0);
      chk("ce_pre_writereg", writereg, 5'd3);
      tick();
    end
    ce = 1'b0;
    repeat (3) begin
      drive(1'b1, 5'd3, 32'hAA, 1'b1, 5'd12, 32'h66);
      chk("ce_off_regwrite", regwrite, 1'b0);
      chk("ce_off_ready", mdu_ready, 1'b0);
      chk("ce_off_stall", stall_req, 1'b0);
      chk("ce_off_hit1", chk_hit1, 1'b1);
      tick();
    end
    ce = 1'b1;
    drive(1'b1, 5'd3, 32'hAA, 1'b0, 5'd0, 32'd0);
    chk("ce_on6_stall", stall_req, 1'b0);
    chk("ce_on6_writereg", writereg, 5'd3);
    tick();
    chk("ce_on7_stall", stall_req, 1'b0);
    tick();
    chk("ce_on8_stall", stall_req, 1'b1);
    chk("ce_on8_writereg", writereg, 5'd11);
    chk("ce_on8_writedata", writedata, 32'h55);
    tick();
    chk("ce_on9_stall", stall_req, 1'b0);
    chk("ce_on9_writereg", writereg, 5'd3);
    tick();
    idle();
    tick();

    // Reset mid-operation discards queued entries
    chk_addr1 = 5'd13;
    drive(1'b1, 5'd3, 32'hAA, 1'b1, 5'd13, 32'h77);
    tick();
    rst_n = 1'b0;
    idle();
    chk("rst_ready", mdu_ready, 1'b0);
    tick();
    rst_n = 1'b1;
    idle();
    chk("post_rst_regwrite", regwrite, 1'b0);
    chk("post_rst_hit1", chk_hit1, 1'b0);
    chk("post_rst_stall", stall_req, 1'b0);
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
